digitube_driver: RTL and testbench
==================================

DIGITUBE_DRIVER -- requirements
Module: digitube_driver

Interface
REQ-001 Parameter DIV, default 50000: clk cycles per digit slot; legal range 1..2^20.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 load  input  1  single-cycle strobe; captures data_in, dp_in and blank_in into the pending registers.
REQ-005 data_in  input  16  hex value; digit i is data_in[4i+3:4i], i=0..3.
REQ-006 dp_in  input  4  bit i=1 lights the decimal point of digit i.
REQ-007 blank_in  input  4  bit i=1 blanks digit i.
REQ-008 digi_out  output  12  scan word {AN3,AN2,AN1,AN0,DP,CG,CF,CE,CD,CC,CB,CA}; AN is one-hot active-high, DP and segments are active-low.
REQ-009 frame_tick  output  1  one-cycle pulse on each frame commit edge (REQ-014).

Function
REQ-010 Prescaler cnt SHALL count 0..DIV-1; tick is asserted when cnt==DIV-1, and cnt returns to 0 on that edge; DIV=1 gives tick every cycle.
REQ-011 Digit index idx (2 bits) SHALL advance by 1 modulo 4 on each tick edge (3 -> 0 wraps).
REQ-012 On load=1, pending data/dp/blank SHALL be overwritten and pending_valid set; repeated loads before a commit: last load wins.
REQ-013 Active display registers (data, dp, blank) SHALL change only on a commit.
REQ-014 Commit edge = tick with idx==3; on it frame_tick=1 for that cycle and, if pending_valid was 1 before the edge, active <= pending and pending_valid cleared.
REQ-015 load coincident with a commit edge: the pending contents held before the edge are committed; the new load is written to pending with pending_valid=1 and commits at the next wrap.
REQ-016 digi_out SHALL be a combinational decode of registered idx and active registers only; no combinational path from any input to digi_out.
REQ-017 For non-blanked digit idx: digi_out[11:8]=1<<idx; digi_out[7]=~dp[idx]; digi_out[6:0]=segment code of the active nibble.
REQ-018 Blanked digit: digi_out=12'h0FF (AN 0000, DP off, all segments off).
REQ-019 Segment codes (CG..CA, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-020 Each digit slot SHALL last exactly DIV cycles; a full frame is 4*DIV cycles, with frame_tick period 4*DIV.

Reset
REQ-021 While reset is low: cnt=0, idx=0, active data=16'h0000, dp=4'h0, blank=4'hF, pending cleared, pending_valid=0, frame_tick=0, so digi_out=12'h0FF.
REQ-022 Reset asserted mid-frame SHALL take effect without waiting for clk and SHALL discard any pending load.
REQ-023 After reset release, the first tick occurs DIV cycles later and the first commit edge 4*DIV cycles later.

Verification (DIV=4)
REQ-024 Reset low -> digi_out=12'h0FF and frame_tick=0 at all times, with no clk edge needed.
REQ-025 Release reset, then load 16'h1234 with dp=0 and blank=0 in the following cycle -> output stays 12'h0FF until the first commit (edge 16), then digit0=12'h199, digit1=12'h2B0, each held 4 cycles.
REQ-026 Load 16'h1111, then load 16'h2222 before the commit -> only 2222 is displayed after the commit; 1111 is never shown.
REQ-027 Load 16'hAAAA on a commit edge while 16'h5555 is pending -> 5555 is shown for one frame, then AAAA from the next commit.
REQ-028 data 16'h00A0, dp 4'b0001, blank 4'b0010 committed -> digit0=12'h140, digit1=12'h0FF, digit2=12'h4C0; frame_tick pulses every 16 cycles.
REQ-029 Assert reset mid-frame with a load pending -> digi_out=12'h0FF immediately; after release, the old pending value never appears.

Source files
------------

// File: rtl/digitube_driver_if.sv
// digitube_driver_if
//   Groups the load/data side and the scan outputs of the 4-digit
//   seven-segment scan driver.
//   master : drives load, data_in, dp_in, blank_in; observes digi_out, frame_tick
//   slave  : the driver itself
//   load       1  single-cycle strobe capturing data_in/dp_in/blank_in
//   data_in   16  four hex nibbles, digit i = data_in[4i+3:4i]
//   dp_in      4  per-digit decimal point enable
//   blank_in   4  per-digit blank enable
//   digi_out  12  {AN3..AN0, DP, CG..CA}; AN active-high, DP/segments active-low
//   frame_tick 1  one-cycle pulse on each frame commit edge
interface digitube_driver_if;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [11:0] digi_out;
  logic        frame_tick;

  modport master (
    output load, data_in, dp_in, blank_in,
    input  digi_out, frame_tick
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    output digi_out, frame_tick
  );
endinterface

// File: rtl/digitube_driver.sv
// digitube_driver
//   Time-multiplexed driver for a 4-digit common-anode seven-segment
//   display. A prescaler divides clk into DIV-cycle digit slots; the digit
//   index walks 0..3. New display content is staged in pending registers
//   by load and only copied to the active registers at the frame boundary
//   (tick while idx==3), so a frame is never shown half-updated.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low
//     bus    digitube_driver_if.slave (load/data_in/dp_in/blank_in in,
//            digi_out/frame_tick out)
//   Parameter:
//     DIV    clk cycles per digit slot, 1..2^20
module digitube_driver #(
  parameter int unsigned DIV = 50000
) (
  input logic             clk,
  input logic             reset,
  digitube_driver_if.slave bus
);

  // 20 bits covers DIV-1 for the largest legal DIV of 2^20.
  localparam logic [19:0] CNT_LAST = 20'(DIV - 1);

  logic [19:0] cnt;
  logic [1:0]  idx;
  logic        tick;
  logic        commit;

  logic [15:0] pend_data;
  logic [3:0]  pend_dp;
  logic [3:0]  pend_blank;
  logic        pend_valid;

  logic [15:0] act_data;
  logic [3:0]  act_dp;
  logic [3:0]  act_blank;

  logic [3:0]  nibble;
  logic [6:0]  seg;
  logic [11:0] digi;

  assign tick   = (cnt == CNT_LAST);
  assign commit = tick && (idx == 2'd3);

  // Slot prescaler
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end

  // Digit index, wraps 3 -> 0 naturally in 2 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Pending stage. A load on the commit edge wins over the clear, so the
  // new value stays valid for the next frame while the old one is committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_data  <= 16'h0000;
      pend_dp    <= 4'h0;
      pend_blank <= 4'h0;
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_data  <= bus.data_in;
      pend_dp    <= bus.dp_in;
      pend_blank <= bus.blank_in;
      pend_valid <= 1'b1;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end
  end

  // Active display registers; reset blanks every digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_data  <= 16'h0000;
      act_dp    <= 4'h0;
      act_blank <= 4'hF;
    end else if (commit && pend_valid) begin
      act_data  <= pend_data;
      act_dp    <= pend_dp;
      act_blank <= pend_blank;
    end
  end

  // Active-low segment patterns, bit order CG..CA
  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

  // Output decode uses registered state only, so inputs never reach digi_out
  // combinationally.
  always_comb begin
    nibble = act_data[{idx, 2'b00} +: 4];
    digi   = 12'h0FF;
    if (!act_blank[idx]) begin
      digi = {4'b0001 << idx, ~act_dp[idx], seg};
    end
  end

  assign bus.digi_out   = digi;
  assign bus.frame_tick = commit;

endmodule

// File: tb/tb_digitube_driver.sv
// tb_digitube_driver
//   Directed bench for digitube_driver with DIV=4. Edge numbers count rising
//   clk edges since the most recent reset release; after edge e the slot is
//   idx = (e/4)%4, and commit edges are 16, 32, 48, ...
module tb_digitube_driver;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cur      = 0;

  digitube_driver_if bus ();

  digitube_driver #(.DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ft(input string tag, input logic exp);
    chk(tag, {11'd0, bus.frame_tick}, {11'd0, exp});
  endtask

  // Advance to 1 time unit after edge e.
  task automatic adv(input int e);
    while (cur < e) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.load     = 1'b1;
    bus.data_in  = d;
    bus.dp_in    = dp;
    bus.blank_in = bl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load     = 1'b0;
    bus.data_in  = 16'h0000;
    bus.dp_in    = 4'h0;
    bus.blank_in = 4'h0;

    // Reset without any clock edge
    #1 reset = 1'b0;
    #1;
    chk("reset_noclk_digi", bus.digi_out, 12'h0FF);
    chk_ft("reset_noclk_ft", 1'b0);
    @(posedge clk); #1;
    chk("reset_edge_digi", bus.digi_out, 12'h0FF);
    @(posedge clk); #1;
    reset = 1'b1;
    cur   = 0;

    // First frame: load 1234 one cycle after release
    adv(1);  do_load(16'h1234, 4'h0, 4'h0);
    adv(2);  bus.load = 1'b0;
    chk("pre_commit_e2", bus.digi_out, 12'h0FF);
    adv(14); chk_ft("ft_e14", 1'b0);
    adv(15); chk("pre_commit_e15", bus.digi_out, 12'h0FF);
    chk_ft("ft_first_commit", 1'b1);
    adv(16); chk("f1_d0", bus.digi_out, 12'h199);
    chk_ft("ft_after_commit", 1'b0);
    adv(19); chk("f1_d0_hold", bus.digi_out, 12'h199);
    adv(20); chk("f1_d1", bus.digi_out, 12'h2B0);
    adv(24); chk("f1_d2", bus.digi_out, 12'h4A4);
    adv(28); chk("f1_d3", bus.digi_out, 12'h8F9);
    adv(31); chk_ft("ft_e31", 1'b1);
    adv(32); chk("f2_d0_nochange", bus.digi_out, 12'h199);

    // Last load wins: 1111 then 2222
    do_load(16'h1111, 4'h0, 4'h0);
    adv(33); do_load(16'h2222, 4'h0, 4'h0);
    adv(34); bus.load = 1'b0;
    adv(36); chk("f2_d1_old", bus.digi_out, 12'h2B0);
    adv(48); chk("f3_d0_2222", bus.digi_out, 12'h1A4);
    adv(52); chk("f3_d1_2222", bus.digi_out, 12'h2A4);

    // 5555 pending, AAAA loaded on the commit edge
    do_load(16'h5555, 4'h0, 4'h0);
    adv(53); bus.load = 1'b0;
    adv(56); chk("f3_d2_2222", bus.digi_out, 12'h4A4);
    adv(60); chk("f3_d3_2222", bus.digi_out, 12'h8A4);
    adv(63); do_load(16'hAAAA, 4'h0, 4'h0);
    adv(64); bus.load = 1'b0;
    chk("f4_d0_5555", bus.digi_out, 12'h192);
    adv(68); chk("f4_d1_5555", bus.digi_out, 12'h292);
    adv(76); chk("f4_d3_5555", bus.digi_out, 12'h892);
    adv(80); chk("f5_d0_aaaa", bus.digi_out, 12'h188);
    adv(84); chk("f5_d1_aaaa", bus.digi_out, 12'h288);

    // Decimal point and blanking
    do_load(16'h00A0, 4'b0001, 4'b0010);
    adv(85); bus.load = 1'b0;
    adv(96);  chk("f6_d0_dp", bus.digi_out, 12'h140);
    adv(100); chk("f6_d1_blank", bus.digi_out, 12'h0FF);
    adv(104); chk("f6_d2_a", bus.digi_out, 12'h4C0);
    adv(108); chk("f6_d3_0", bus.digi_out, 12'h8C0);
    adv(110); chk_ft("ft_e110", 1'b0);
    adv(111); chk_ft("ft_e111", 1'b1);
    adv(112); chk_ft("ft_e112", 1'b0);

    // Remaining segment codes
    do_load(16'hFEDC, 4'b1010, 4'h0);
    adv(113); bus.load = 1'b0;
    adv(127); chk_ft("ft_e127", 1'b1);
    adv(128); chk("f8_d0_c", bus.digi_out, 12'h1C6);
    adv(132); chk("f8_d1_d_dp", bus.digi_out, 12'h221);
    adv(136); chk("f8_d2_e", bus.digi_out, 12'h486);
    adv(140); chk("f8_d3_f_dp", bus.digi_out, 12'h80E);
    do_load(16'h9B76, 4'h0, 4'h0);
    adv(141); bus.load = 1'b0;
    adv(144); chk("f9_d0_6", bus.digi_out, 12'h182);
    adv(148); chk("f9_d1_7", bus.digi_out, 12'h2F8);
    adv(152); chk("f9_d2_b", bus.digi_out, 12'h483);
    adv(156); chk("f9_d3_9", bus.digi_out, 12'h890);

    // Mid-frame reset with 7777 pending
    do_load(16'h7777, 4'h0, 4'h0);
    adv(157); bus.load = 1'b0;
    adv(158);
    reset = 1'b0;
    #1;
    chk("midreset_digi", bus.digi_out, 12'h0FF);
    chk_ft("midreset_ft", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_held", bus.digi_out, 12'h0FF);
    reset = 1'b1;
    cur   = 0;
    adv(14); chk_ft("rr_ft_e14", 1'b0);
    adv(15); chk_ft("rr_ft_e15", 1'b1);
    adv(16); chk("rr_d0", bus.digi_out, 12'h0FF);
    adv(20); chk("rr_d1", bus.digi_out, 12'h0FF);
    adv(24); chk("rr_d2", bus.digi_out, 12'h0FF);
    adv(28); chk("rr_d3", bus.digi_out, 12'h0FF);
    adv(32); chk("rr_f2_d0", bus.digi_out, 12'h0FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
